// File: rtl/clk_div_ctrl.sv
// Run-time controller for a programmable clock divider. Ratio/enable updates
// arrive over valid/ready and take effect only at a falling edge of clk_out.
module clk_div_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             cfg_en,
    output logic             clk_out,
    output logic             clk_en,
    output logic             running,
    output logic [WIDTH-1:0] div_active
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_pend_div;
    logic             r_pend_en;
    logic             r_clk_out;
    logic             r_clk_en;

    logic             w_xfer;
    logic             w_wrap;
    logic [WIDTH-1:0] w_eff_div;

    assign cfg_ready  = (r_state != PEND);
    assign running    = (r_state != IDLE);
    assign clk_out    = r_clk_out;
    assign clk_en     = r_clk_en;
    assign div_active = r_div;

    assign w_xfer    = cfg_valid && cfg_ready;
    assign w_eff_div = (cfg_div == '0) ? WIDTH'(1) : cfg_div;
    // r_div is never 0, so the compare value cannot underflow.
    assign w_wrap    = (r_cnt == r_div - WIDTH'(1));

    // NOTE: every register here, pending config included, is reset so that a
    // reset mid-PEND cannot leak a stale word into the next run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_div      <= WIDTH'(DEFAULT_DIV);
            r_pend_div <= '0;
            r_pend_en  <= 1'b0;
            r_clk_out  <= 1'b0;
            r_clk_en   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; the default below is overridden
            // later in the same block only on the rising-edge wrap.
            r_clk_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_clk_out <= 1'b0;
                    r_cnt     <= '0;
                    if (w_xfer) begin
                        r_div <= w_eff_div;
                        if (cfg_en) begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_wrap) begin
                        r_cnt     <= '0;
                        r_clk_out <= ~r_clk_out;
                        r_clk_en  <= ~r_clk_out;
                    end else begin
                        r_cnt <= r_cnt + WIDTH'(1);
                    end
                    if (w_xfer) begin
                        r_pend_div <= w_eff_div;
                        r_pend_en  <= cfg_en;
                        r_state    <= PEND;
                    end
                end
                PEND: begin
                    if (w_wrap && r_clk_out) begin
                        r_cnt     <= '0;
                        r_clk_out <= 1'b0;
                        if (r_pend_en) begin
                            r_div   <= r_pend_div;
                            r_state <= RUN;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_wrap) begin
                        r_cnt     <= '0;
                        r_clk_out <= 1'b1;
                        r_clk_en  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: a period-level reference model predicts every cycle's
// outputs into a queue; a negedge monitor pops and compares.
module tb_clk_div_ctrl;

    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 6;

    logic             clk;
    logic             reset;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_en;
    logic             clk_out;
    logic             clk_en;
    logic             running;
    logic [WIDTH-1:0] div_active;

    clk_div_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_div    (cfg_div),
        .cfg_en     (cfg_en),
        .clk_out    (clk_out),
        .clk_en     (clk_en),
        .running    (running),
        .div_active (div_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    endtask

    // Expected bundle: {clk_out, clk_en, running, cfg_ready, div_active}
    logic [WIDTH+3:0] exp_q[$];

    // Reference model: k = cycles since the current period started; clk_out
    // is high for k in [d, 2d), and a period ends when k reaches 2d.
    bit m_run, m_pend, m_pen, xfer;
    int m_d, m_pdiv, m_k, eff;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run  = 0;
            m_pend = 0;
            m_pen  = 0;
            m_pdiv = 0;
            m_d    = DEFAULT_DIV;
            m_k    = 0;
            exp_q.delete();
        end else begin
            xfer = cfg_valid && !m_pend;
            eff  = (cfg_div == 0) ? 1 : int'(cfg_div);
            if (!m_run) begin
                if (xfer) begin
                    m_d = eff;
                    if (cfg_en) begin
                        m_run = 1;
                        m_k   = 0;
                    end
                end
            end else begin
                m_k++;
                if (m_k == 2 * m_d) begin
                    m_k = 0;
                    if (m_pend) begin
                        m_pend = 0;
                        if (m_pen) m_d = m_pdiv;
                        else       m_run = 0;
                    end
                end
                if (xfer) begin
                    m_pend = 1;
                    m_pdiv = eff;
                    m_pen  = cfg_en;
                end
            end
            exp_q.push_back({m_run && (m_k >= m_d), m_run && (m_k == m_d),
                             m_run, !m_pend, WIDTH'(m_d)});
        end
    end

    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            check("cycle", {clk_out, clk_en, running, cfg_ready, div_active}, exp_q.pop_front());
        end
    end

    task automatic send(input int d, input bit en);
        bit ok, r;
        @(posedge clk); #2;
        cfg_valid = 1'b1;
        cfg_div   = WIDTH'(d);
        cfg_en    = en;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); r = cfg_ready;
            @(posedge clk);
            if (r) begin ok = 1; break; end
        end
        #2 cfg_valid = 1'b0;
        check("send_accept", ok, 1);
    endtask

    // Distance in cycles between two successive clk_en strobes.
    task automatic measure_period(input int exp_period);
        int n;
        bit seen;
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (clk_en) begin seen = 1; break; end
        end
        n = 0;
        if (seen) begin
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk); n++;
                if (clk_en) break;
            end
        end
        check("period", n, exp_period);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; cfg_div = '0; cfg_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_clk_out", clk_out, 0);
        check("rst_clk_en", clk_en, 0);
        check("rst_running", running, 0);
        check("rst_div", div_active, DEFAULT_DIV);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", cfg_ready, 1);

        send(3, 1);
        measure_period(6);
        send(5, 1);
        wait_cycles(12);
        check("ratio5_div", div_active, 5);
        measure_period(10);

        send(4, 1);
        wait_cycles(10);
        send(4, 0);
        wait_cycles(20);
        @(negedge clk);
        check("stop_running", running, 0);
        check("stop_clk_out", clk_out, 0);

        send(0, 1);
        wait_cycles(3);
        @(negedge clk);
        check("div0_div", div_active, 1);
        measure_period(2);

        send(255, 1);
        wait_cycles(520);
        measure_period(510);

        for (int it = 0; it < 25; it++) begin
            int pick, d;
            bit en;
            pick = $urandom_range(0, 9);
            if (pick == 0)      d = 0;
            else if (pick == 1) d = $urandom_range(100, 255);
            else                d = $urandom_range(1, 12);
            en = ($urandom_range(0, 4) != 0);
            wait_cycles($urandom_range(0, 30));
            send(d, en);
        end
        wait_cycles(600);

        // Async reset while a word is pending, with the next word held.
        send(50, 1);
        wait_cycles(5);
        @(posedge clk); #2;
        cfg_valid = 1'b1; cfg_div = 8'd9; cfg_en = 1'b1;
        @(posedge clk); #2;
        @(negedge clk);
        check("pend_ready", cfg_ready, 0);
        #1 reset = 1'b1;
        #1;
        check("arst_running", running, 0);
        check("arst_clk_out", clk_out, 0);
        check("arst_div", div_active, DEFAULT_DIV);
        check("arst_ready", cfg_ready, 1);
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #2 cfg_valid = 1'b0;
        @(negedge clk);
        check("held_div", div_active, 9);
        check("held_running", running, 1);
        measure_period(18);

        wait_cycles(5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
